// File: rtl/cdc_handshake_dest_sink_if.sv
// cdc_handshake_dest_sink_if: strobe/stall and downstream valid/ready bundle for the dest-side sink.
interface cdc_handshake_dest_sink_if #(
   parameter int CNT_W = 4,
   parameter int ERR_W = 32
);
   logic             dest_strobe;
   logic             dest_stall;
   logic             evt_valid;
   logic             evt_ready;
   logic [CNT_W-1:0] pending;
   logic             overflow;
   logic [ERR_W-1:0] error_count;
   modport master (
      output dest_strobe, evt_ready,
      input  dest_stall, evt_valid, pending, overflow, error_count
   );
   modport slave (
      input  dest_strobe, evt_ready,
      output dest_stall, evt_valid, pending, overflow, error_count
   );
endinterface

// File: rtl/cdc_handshake_dest_sink.sv
// cdc_handshake_dest_sink: queues dest-side strobes, services each for a fixed time, presents them downstream.
module cdc_handshake_dest_sink #(
   parameter int CNT_W          = 4,
   parameter int SERVICE_CYCLES = 3,
   parameter int STALL_THRESH   = 12,
   parameter int ERR_W          = 32
) (
   input logic                     dest_clk,
   input logic                     dest_reset,
   cdc_handshake_dest_sink_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SERVICE, PRESENT} state_t;
   localparam logic [7:0] RELOAD = 8'(SERVICE_CYCLES - 1);
   state_t           state_q, state_d;
   logic [7:0]       timer_q, timer_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             stall_q, stall_d, valid_q, valid_d, overflow_q, overflow_d;
   logic             full, retire, accept, drop;
   always_comb begin
      full       = &pending_q;
      retire     = valid_q & bus.evt_ready;
      // a retire on the same edge frees the slot, so a full queue can still accept
      accept     = bus.dest_strobe & (!full | retire);
      drop       = bus.dest_strobe & full & !retire;
      pending_d  = pending_q + CNT_W'(accept) - CNT_W'(retire);
      stall_d    = pending_d >= CNT_W'(STALL_THRESH);
      overflow_d = overflow_q | drop;
      err_d      = err_q + ERR_W'(drop & !(&err_q));
      state_d    = state_q;
      timer_d    = timer_q;
      case (state_q)
         IDLE: if (pending_q != '0) begin
            state_d = SERVICE;
            timer_d = RELOAD;
         end
         SERVICE: if (timer_q == '0) state_d = PRESENT;
                  else timer_d = timer_q - 8'd1;
         PRESENT: if (bus.evt_ready) begin
            state_d = (pending_d != '0) ? SERVICE : IDLE;
            timer_d = RELOAD;
         end
         default: state_d = IDLE;
      endcase
      valid_d = state_d == PRESENT;
   end
   always_ff @(posedge dest_clk or posedge dest_reset) begin
      if (dest_reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         pending_q  <= '0;
         err_q      <= '0;
         stall_q    <= 1'b0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pending_q  <= pending_d;
         err_q      <= err_d;
         stall_q    <= stall_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end
   assign bus.dest_stall  = stall_q;
   assign bus.evt_valid   = valid_q;
   assign bus.pending     = pending_q;
   assign bus.overflow    = overflow_q;
   assign bus.error_count = err_q;
endmodule
